// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control sequencer:
// state encodings, opcode values, datapath mux/ALU codes and the packed
// control word that the output decoder produces.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_TRAP     = 4'd10
  } state_e;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_SHIFT = 6'b110000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_4       = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Sequencer <-> datapath bundle.
//   master (sequencer): inputs opcode, mem_ready; drives all control outputs,
//                       instr_cnt and illegal_op.
//   slave  (datapath) : the mirror image.
interface mc_control_fsm_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_source;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [CNT_W-1:0] instr_cnt;
  logic             illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_cnt, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_cnt, illegal_op
  );
endinterface

// File: rtl/mc_ctrl_out_decode.sv
// Combinational control-word decode for the multi-cycle sequencer.
// Ports: state (current FSM state), op_q (opcode latched in DECODE),
//        mem_ready (memory handshake), ctrl (packed control word).
// Optional feature macro: ILLEGAL_TRAP_EN (TRAP state raises illegal_op).
module mc_ctrl_out_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] op_q,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
        // IR and PC+4 are captured only on the cycle the read completes.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        case (op_q)
          OP_R:     begin ctrl.alu_src_b = SRCB_B;   ctrl.alu_op = ALU_FN;  end
          OP_SHIFT: begin ctrl.alu_src_b = SRCB_IMM; ctrl.alu_op = ALU_FN;  end
          OP_ADDI:  begin ctrl.alu_src_b = SRCB_IMM; ctrl.alu_op = ALU_ADD; end
          OP_ANDI:  begin ctrl.alu_src_b = SRCB_IMM; ctrl.alu_op = ALU_AND; end
          default:  ;
        endcase
      end
      S_ALU_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = (op_q == OP_R) || (op_q == OP_SHIFT);
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: ctrl.illegal_op = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle sequencer for the MIPS-subset datapath. Walks each
// instruction through FETCH/DECODE/EXECUTE/MEM/WB, stalls on mem_ready
// and counts retired instructions.
// Ports: clk, reset (synchronous, active-high), bus (master side of
//        mc_control_fsm_if: opcode/mem_ready in, datapath controls,
//        instr_cnt and illegal_op out).
// Parameter: CNT_W - width of the retire counter.
// Optional feature macro: ILLEGAL_TRAP_EN - unknown opcodes enter a sticky
// TRAP state instead of retiring as a NOP.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  mc_control_fsm_if.master  bus
);

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  ctrl_t            ctrl_dec, ctrl;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        // Dispatch on the live opcode; op_q holds it for the later states.
        op_d = bus.opcode;
        case (bus.opcode)
          OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
          OP_R, OP_SHIFT, OP_ADDI, OP_ANDI:   state_d = S_EXEC;
          OP_BEQ:                             state_d = S_BRANCH;
          OP_J:                               state_d = S_JUMP;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
            retire  = 1'b1;
`endif
          end
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WR: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC: state_d = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    if (retire) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  mc_ctrl_out_decode u_dec (
    .state     (state_q),
    .op_q      (op_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl_dec)
  );

  // Every output is held low for as long as reset is asserted.
  assign ctrl = reset ? '0 : ctrl_dec;

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign bus.instr_cnt     = reset ? '0 : cnt_q;

endmodule
